// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 8N1 UART receiver with mid-bit sampling and a FWFT byte FIFO
module uart_rx_buffered #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
  localparam int CNT_W        = $clog2(BAUD_DIVISOR + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int OCC_W        = PTR_W + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIVISOR - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             sync1;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push_q;

  logic             half_done;
  logic             bit_done;
  logic             cnt_clr;
  logic             sample_bit;
  logic             stop_good;
  logic             stop_bad;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  assign half_done = (cnt == HALF_LAST);
  assign bit_done  = (cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rxs) state_d = S_START;
      S_START: if (half_done) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (bit_done && (bit_idx == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_done) state_d = rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr    = 1'b0;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      S_IDLE:  cnt_clr = 1'b1;
      S_START: cnt_clr = half_done;
      S_DATA: begin
        cnt_clr    = bit_done;
        sample_bit = bit_done;
      end
      S_STOP: begin
        cnt_clr   = bit_done;
        stop_good = bit_done & rxs;
        stop_bad  = bit_done & ~rxs;
      end
      S_BREAK: cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit timing and deserialisation; the finished byte waits in shreg for the push cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      push_q    <= stop_good;
      frame_err <= stop_bad;
      if (state_q != S_DATA) begin
        bit_idx <= 3'd0;
      end else if (sample_bit) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (sample_bit) begin
        shreg <= {rxs, shreg[7:1]};
      end
    end
  end

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;
  logic             full;
  logic             wr_en;

  assign rx_valid = (fifo_count != '0);
  assign pop      = rx_valid & rx_ready;
  assign full     = (fifo_count == FULL_CNT);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en    = push_q & (~full | pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push_q & full & ~pop;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - directed self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;

  localparam int BAUD = 234;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_both = 0;
  logic [7:0] popped[$];

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLOCK_FREQUENCY(27000000),
    .BAUD_RATE(115200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .fifo_count(fifo_count)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) n_valid++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (frame_err && overrun) n_both++;
      if (rx_valid && rx_ready) popped.push_back(rx_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left just after a rising edge; bits go LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // exp holds the expected bytes, first popped in the low byte.
  task automatic check_pops(input string tag, input int base, input int n, input logic [63:0] exp);
    logic [63:0] e;
    logic [31:0] got;
    e = exp;
    check_eq({tag, "_npop"}, popped.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < popped.size()) ? {24'h0, popped[base + i]} : 32'hxxxxxxxx;
      check_eq($sformatf("%s_byte%0d", tag, i), got, {24'h0, e[8*i +: 8]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, rx_valid, 0);
    check_eq({tag, "_data"}, rx_data, 0);
    check_eq({tag, "_count"}, fifo_count, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int b;
    int v0;
    int f0;
    int o0;
    int mn;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(5);

    // Single byte straight through
    rx_ready = 1'b1;
    b = popped.size();
    v0 = n_valid;
    send_frame(8'h54, 1'b1);
    idle(20);
    check_eq("t1_valid_cycles", n_valid - v0, 1);
    check_pops("t1", b, 1, 64'h54);
    check_eq("t1_count", fifo_count, 0);
    check_eq("t1_ferr", n_ferr, 0);
    check_eq("t1_ovr", n_ovr, 0);

    // Back-to-back burst into a stalled consumer
    rx_ready = 1'b0;
    b = popped.size();
    o0 = n_ovr;
    send_frame(8'h54, 1'b1);
    send_frame(8'h65, 1'b1);
    send_frame(8'h73, 1'b1);
    send_frame(8'h74, 1'b1);
    check_eq("t2_count_full", fifo_count, 4);
    check_eq("t2_head", rx_data, 8'h54);
    send_frame(8'h0D, 1'b1);
    send_frame(8'h0A, 1'b1);
    check_eq("t2_overruns", n_ovr - o0, 2);
    check_eq("t2_count_still_full", fifo_count, 4);
    rx_ready = 1'b1;
    idle(10);
    check_pops("t2", b, 4, 64'h74_73_65_54);
    check_eq("t2_count_drained", fifo_count, 0);

    // False start: 50-cycle glitch
    b = popped.size();
    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(300);
    check_eq("t3_no_valid", n_valid - v0, 0);
    check_eq("t3_no_ferr", n_ferr - f0, 0);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check_pops("t3", b, 1, 64'h5A);

    // Framing error followed by a long break
    b = popped.size();
    f0 = n_ferr;
    send_frame(8'hA5, 1'b0);
    idle(2000);
    rx = 1'b1;
    idle(300);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check_eq("t4_ferr_once", n_ferr - f0, 1);
    check_pops("t4", b, 1, 64'h3C);

    // Reset mid-frame discards both buffered and partial bytes
    rx_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    check_eq("t5_count_pre", fifo_count, 1);
    b = popped.size();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(1250);
        rst_n = 1'b0;
        idle(1);
        check_reset_outputs("t5_rst");
        rst_n = 1'b1;
      end
    join
    rx_ready = 1'b1;
    idle(50);
    send_frame(8'h81, 1'b1);
    idle(20);
    check_pops("t5", b, 1, 64'h81);

    // Pop coincides with a push into a full FIFO
    rx_ready = 1'b0;
    b = popped.size();
    o0 = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    check_eq("t6_count_full", fifo_count, 4);
    mn = 4;
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (2226) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
      begin
        for (int i = 0; i < 2300; i++) begin
          @(negedge clk);
          if (fifo_count < mn) mn = fifo_count;
        end
      end
    join
    check_eq("t6_min_count", mn, 4);
    check_eq("t6_no_overrun", n_ovr - o0, 0);
    check_eq("t6_count_after", fifo_count, 4);
    rx_ready = 1'b1;
    idle(10);
    check_pops("t6", b, 5, 64'h99_44_33_22_11);
    check_eq("t6_count_drained", fifo_count, 0);
    check_eq("flags_exclusive", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
